// File: rtl/ps2_pkg.sv
// Shared PS/2 scancodes, direction encoding and FSM state types.
// The key lookup maps a (prefix, scancode) pair onto a snake direction.
package ps2_pkg;

  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_UP_X    = 8'h75;
  localparam logic [7:0] SC_RIGHT_X = 8'h74;
  localparam logic [7:0] SC_DOWN_X  = 8'h72;
  localparam logic [7:0] SC_LEFT_X  = 8'h6B;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_A       = 8'h1C;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } key_hit_t;

  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t k;
    k = '0;
    if (ext) begin
      case (code)
        SC_UP_X:    k = '{hit: 1'b1, dir: DIR_UP};
        SC_RIGHT_X: k = '{hit: 1'b1, dir: DIR_RIGHT};
        SC_DOWN_X:  k = '{hit: 1'b1, dir: DIR_DOWN};
        SC_LEFT_X:  k = '{hit: 1'b1, dir: DIR_LEFT};
        default:    k = '0;
      endcase
    end else begin
      case (code)
        SC_W:    k = '{hit: 1'b1, dir: DIR_UP};
        SC_D:    k = '{hit: 1'b1, dir: DIR_RIGHT};
        SC_S:    k = '{hit: 1'b1, dir: DIR_DOWN};
        SC_A:    k = '{hit: 1'b1, dir: DIR_LEFT};
        default: k = '0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser, 11-bit frame receiver and inter-edge timeout.
// byte_vld is combinational on the stop-bit falling-edge cycle; frame_err is a registered pulse.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_dat,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  rx_state_t     state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity;
  logic [TW-1:0] to_cnt;

  logic fall;
  logic din;
  logic stop_ok;

  assign fall     = clk_prev & ~clk_sync[1];
  assign din      = dat_sync[1];
  // Odd parity across the eight data bits plus the parity bit, and a high stop bit.
  assign stop_ok  = din & (^{shift, parity});
  assign byte_vld = fall && (state == RX_STOP) && stop_ok;
  assign byte_dat = shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_prev  <= 1'b1;
      state     <= RX_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      parity    <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!din) begin
              state   <= RX_DATA;
              shift   <= '0;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shift   <= {din, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity <= din;
            state  <= RX_STOP;
          end
          RX_STOP: begin
            if (!stop_ok) frame_err <= 1'b1;
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYC)) begin
          state     <= RX_IDLE;
          shift     <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: decodes make/break/extended scancodes into held-key state
// and a queue of direction commands; a push into an empty queue shows dir_valid one cycle later.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2000,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       dir_valid,
  output logic [1:0] dir,
  input  logic       dir_ready,
  output logic [3:0] key_down,
  output logic       frame_err,
  output logic       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0] byte_dat;
  logic       byte_vld;

  ps2_frame_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_dat  (byte_dat),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  dec_state_t    dec_state;
  dec_state_t    dec_next;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  key_hit_t hit;
  logic     ext;
  logic     brk;
  logic     is_prefix;
  logic     make_key;
  logic     break_key;
  logic     push;
  logic     pop;
  logic     full;
  logic     wr_en;

  assign dir_valid = (count != '0);
  assign dir       = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign pop       = dir_valid && dir_ready;

  always_comb begin
    ext       = (dec_state == DEC_EXT) || (dec_state == DEC_EXT_BRK);
    brk       = (dec_state == DEC_BRK) || (dec_state == DEC_EXT_BRK);
    is_prefix = (byte_dat == SC_E0) || (byte_dat == SC_F0);
    hit       = key_lookup(ext, byte_dat);
    make_key  = byte_vld && !is_prefix && hit.hit && !brk;
    break_key = byte_vld && !is_prefix && hit.hit && brk;
    // Typematic repeats of an already-held key must not queue another command.
    push      = make_key && !key_down[hit.dir];
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    wr_en     = push && (!full || pop);
    dec_next  = DEC_BASE;
    if (byte_dat == SC_E0)
      dec_next = DEC_EXT;
    else if (byte_dat == SC_F0)
      dec_next = (dec_state == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_state <= DEC_BASE;
      key_down  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      dropped <= push && full && !pop;
      if (byte_vld) dec_state <= dec_next;
      if (make_key) key_down[hit.dir] <= 1'b1;
      if (break_key) key_down[hit.dir] <= 1'b0;
      if (wr_en) begin
        mem[wr_ptr] <= hit.dir;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: bit-banged PS/2 frames with hand-computed results.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       dir_ready = 1'b0;
  logic       dir_valid;
  logic [1:0] dir;
  logic [3:0] key_down;
  logic       frame_err;
  logic       dropped;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int drop_cnt = 0;
  int f0;
  int d0;
  logic [1:0] pops[$];

  always #5 clk = ~clk;

  // Small clock/timeout values keep the timeout reachable: TIMEOUT_CYC = 1*200 = 200 cycles.
  ps2_key_ctrl #(
    .CLK_HZ     (1000000),
    .TIMEOUT_US (200),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .dir_valid (dir_valid),
    .dir       (dir),
    .dir_ready (dir_ready),
    .key_down  (key_down),
    .frame_err (frame_err),
    .dropped   (dropped)
  );

  always @(posedge clk) begin
    if (frame_err) ferr_cnt++;
    if (dropped) drop_cnt++;
    if (dir_valid && dir_ready) pops.push_back(dir);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < pops.size()) return 32'(pops[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // One PS/2 bit: 40 system cycles, data set up well before the falling edge.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #100 ps2_clk = 1'b0;
    #200 ps2_clk = 1'b1;
    #100;
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    logic p;
    p = ~(^b) ^ bad;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    #400;
  endtask

  task automatic partial(input int n);
    ps2_bit(1'b0);
    for (int i = 1; i < n; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
  endtask

  logic [7:0] codes [5];

  initial begin
    codes = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h1D};
    #20;
    chk("rst_valid", 32'(dir_valid), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_keys", 32'(key_down), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_drop", 32'(dropped), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #100;

    // W make with consumer stalled, then release and drain
    send(8'h1D, 1'b0);
    chk("w_valid", 32'(dir_valid), 32'd1);
    chk("w_dir", 32'(dir), 32'd0);
    chk("w_keys", 32'(key_down), 32'b0001);
    chk("w_ferr", 32'(ferr_cnt), 32'd0);
    send(8'hF0, 1'b0); send(8'h1D, 1'b0);
    chk("w_rel", 32'(key_down), 32'd0);
    @(negedge clk) dir_ready = 1'b1;
    #100;
    chk("w_npop", 32'(pops.size()), 32'd1);
    chk("w_pop0", pop_at(0), 32'd0);
    chk("w_empty", 32'(dir_valid), 32'd0);

    // Extended right arrow with a typematic repeat, then extended break
    pops.delete();
    send(8'hE0, 1'b0); send(8'h74, 1'b0);
    chk("x_make", 32'(key_down), 32'b0010);
    send(8'hE0, 1'b0); send(8'h74, 1'b0);
    chk("x_rep", 32'(key_down), 32'b0010);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h74, 1'b0);
    chk("x_brk", 32'(key_down), 32'd0);
    chk("x_npop", 32'(pops.size()), 32'd1);
    chk("x_pop0", pop_at(0), 32'd1);

    // Bad parity on A is rejected, a clean A is accepted
    pops.delete();
    f0 = ferr_cnt;
    send(8'h1C, 1'b1);
    chk("par_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("par_keys", 32'(key_down), 32'd0);
    chk("par_npop", 32'(pops.size()), 32'd0);
    send(8'h1C, 1'b0);
    chk("a_pop0", pop_at(0), 32'd3);
    chk("a_keys", 32'(key_down), 32'b1000);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);

    // Frame abandoned after 5 data bits times out; next S frame is clean
    pops.delete();
    f0 = ferr_cnt;
    partial(6);
    #3000;
    chk("to_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("to_keys", 32'(key_down), 32'd0);
    send(8'h1B, 1'b0);
    chk("s_npop", 32'(pops.size()), 32'd1);
    chk("s_pop0", pop_at(0), 32'd2);
    chk("s_ferr", 32'(ferr_cnt - f0), 32'd1);
    send(8'hF0, 1'b0); send(8'h1B, 1'b0);

    // Overflow: four queued, fifth dropped, then drain in order
    @(negedge clk) dir_ready = 1'b0;
    pops.delete();
    d0 = drop_cnt;
    for (int i = 0; i < 5; i++) begin
      send(codes[i], 1'b0);
      if (i == 3) chk("ov_nodrop", 32'(drop_cnt - d0), 32'd0);
      if (i < 4) begin
        send(8'hF0, 1'b0); send(codes[i], 1'b0);
      end
    end
    chk("ov_drop", 32'(drop_cnt - d0), 32'd1);
    chk("ov_valid", 32'(dir_valid), 32'd1);
    chk("ov_head", 32'(dir), 32'd0);
    @(negedge clk) dir_ready = 1'b1;
    #200;
    chk("ov_npop", 32'(pops.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("ov_pop%0d", i), pop_at(i), 32'(i));
    send(8'hF0, 1'b0); send(8'h1D, 1'b0);
    chk("ov_rel", 32'(key_down), 32'd0);

    // Reset mid-frame after an E0 prefix, with S held
    send(8'h1B, 1'b0);
    chk("hold_s", 32'(key_down), 32'b0100);
    send(8'hE0, 1'b0);
    partial(4);
    rst_n = 1'b0;
    #50;
    chk("mr_keys", 32'(key_down), 32'd0);
    chk("mr_valid", 32'(dir_valid), 32'd0);
    chk("mr_dir", 32'(dir), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    chk("mr_drop", 32'(dropped), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #100;
    pops.delete();
    f0 = ferr_cnt;
    send(8'h75, 1'b0);
    chk("pr_npop", 32'(pops.size()), 32'd0);
    chk("pr_keys", 32'(key_down), 32'd0);
    send(8'h1D, 1'b0);
    chk("pr_pop0", pop_at(0), 32'd0);
    chk("pr_w", 32'(key_down), 32'b0001);
    chk("pr_ferr", 32'(ferr_cnt - f0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sequences the PS/2 keyboard receive path inside the system clock domain: synchronises ps2_clk/ps2_data, frames and checks 11-bit scancode frames, and decodes make/break/extended prefixes.
- Maintains held-key state for the direction keys.
- Queues direction commands to the snake game logic over a valid/ready handshake.
- Sits between the keyboard pins and the game FSM; it replaces direct use of raw scancodes.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used only to derive TIMEOUT_CYC.
- TIMEOUT_US, 2000, maximum gap between PS/2 falling edges inside one frame.
- DEPTH, 4, direction queue depth; must be a power of two, minimum 2.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- ps2_clk, in, 1, raw PS/2 clock pin, asynchronous to clk.
- ps2_data, in, 1, raw PS/2 data pin, asynchronous to clk.
- dir_valid, out, 1, queue head valid.
- dir, out, 2, queue head direction: 0=up, 1=right, 2=down, 3=left.
- dir_ready, in, 1, consumer accepts head when dir_valid && dir_ready.
- key_down, out, 4, held state indexed by dir encoding.
- frame_err, out, 1, one-cycle pulse on a bad frame or timeout.
- dropped, out, 1, one-cycle pulse when a command is lost because the queue is full.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: frame FSM IDLE, decoder BASE, queue empty, dir_valid=0, dir=0, key_down=0, frame_err=0, dropped=0. Synchroniser flops reset to 1 (PS/2 idle level).
- Input path: 2-flop synchroniser on each pin. A falling edge is the synchronised clk going 1->0 (registered previous value). All sampling uses the synchronised data on the falling-edge cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 -> DATA and clear the shift register. Data=1 is ignored (no error).
  - DATA: shift 8 bits LSB first; after the 8th bit -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: require stop=1 and odd parity over data+parity. On pass, emit an internal byte strobe for one cycle. On fail, pulse frame_err. Either way -> IDLE.
- Timeout: a cycle counter runs in any state except IDLE and clears on every falling edge. When it reaches TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US, go to IDLE, discard the partial byte and pulse frame_err.
- Decoder FSM states: BASE, EXT, BRK, EXT_BRK. Advances only on the byte strobe.
  - BASE: E0 -> EXT; F0 -> BRK; else decode as a non-extended make.
  - EXT: F0 -> EXT_BRK; else decode as an extended make, -> BASE.
  - BRK: decode as a non-extended break, -> BASE.
  - EXT_BRK: decode as an extended break, -> BASE.
  - Any E0/F0 arriving in an unexpected state restarts from the corresponding prefix state.
- Key map:
  - Extended: 75=up, 74=right, 72=down, 6B=left.
  - Non-extended: 1D(W)=up, 23(D)=right, 1B(S)=down, 1C(A)=left.
  - Other codes: no effect beyond the state return.
- Make: if key_down[d]=0, set it and push d. If key_down[d] is already 1 (typematic repeat), do not push.
- Break: clear key_down[d]; no push. key_down updates the cycle after the byte strobe.
- Queue: FIFO of DEPTH entries; the head is shown on dir while dir_valid=1.
  - Pop on dir_valid && dir_ready.
  - Push while full: drop the new entry and pulse dropped.
  - Simultaneous push and pop while full: the pop frees space and the push succeeds, no drop.
  - Push into an empty queue: dir_valid rises the next cycle. Latency is 1 cycle from the stop-bit falling edge to dir_valid.
- Reset mid-frame: all state clears immediately; the next frame must start from a fresh start bit.

Decomposition:
- Shared package (ps2_pkg): scancode constants (E0, F0, arrow and WASD codes), direction encoding constants, frame and decoder state encodings.
- Sub-module ps2_frame_rx: synchroniser, frame FSM and timeout. Outputs byte, byte strobe and frame_err.
- ps2_key_ctrl holds the decoder, key_down and the queue.

Test Plan:
- Frame 1D (W), correct parity -> after the stop bit, dir_valid=1 and dir=0, key_down=0001; frame_err never pulses.
- Sequence E0 74, E0 74, E0 F0 74, dir_ready=1 -> exactly one dir=1 pop; key_down[1] goes 1 then 0.
- Frame with wrong parity on byte 1C -> frame_err pulses once; no push; key_down unchanged. A following valid 1C pushes dir=3.
- Stop after 5 data bits, wait beyond TIMEOUT_CYC -> one frame_err pulse. A following full 1B frame decodes as dir=2.
- dir_ready=0, DEPTH=4, five distinct makes (release each between) -> 4 entries held, dropped pulses on the 5th. Releasing dir_ready pops them in arrival order.
- rst_n asserted mid-frame and after an E0 prefix -> outputs at reset values. A subsequent 75 alone is ignored (not treated as extended).
